bist_access_arbiter: RTL and testbench

Registered, parametrised arbiter that hands a memory's single access port between the functional datapath and the MBIST controller under the `NbarT` mode request. Unlike a plain 2:1 select, mode changes go through a handshaked state machine with enforced quiet cycles, a stall to the functional master, and a grant to the BIST engine. It sits between the functional master / BIST controller and the memory under test.

---
 rtl/bist_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bist_access_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_access_arbiter.sv
// bist_access_arbiter: hands a memory's single access port between the
// functional master and the MBIST controller. Mode changes requested on NbarT
// pass through ENTER/EXIT settle states with quiet memory cycles, stalling the
// functional master and granting the BIST engine only once the port is quiet.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   NbarT                      mode request (0 = normal, 1 = test)
//   func_cs/we/addr/din        functional master access
//   bist_cs/we/addr/din        BIST controller access
//   mem_cs/we/addr/din         registered memory port
//   func_stall                 functional master must hold off
//   bist_grant                 BIST controller owns the port
//   bist_access_cnt            forwarded BIST access count (BIST_ACCESS_CNT_EN only)
//
// Optional feature macro: BIST_ACCESS_CNT_EN
module bist_access_arbiter #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  NbarT,
  input  logic                  func_cs,
  input  logic                  func_we,
  input  logic [ADDR_WIDTH-1:0] func_addr,
  input  logic [DATA_WIDTH-1:0] func_din,
  input  logic                  bist_cs,
  input  logic                  bist_we,
  input  logic [ADDR_WIDTH-1:0] bist_addr,
  input  logic [DATA_WIDTH-1:0] bist_din,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  func_stall,
`ifdef BIST_ACCESS_CNT_EN
  output logic [15:0]           bist_access_cnt,
`endif
  output logic                  bist_grant
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_TEST   = 2'd2;
  localparam logic [1:0] ST_EXIT   = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      settle_cnt, settle_cnt_nxt;
  logic                  mem_cs_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_din_nxt;
  logic                  func_stall_nxt, bist_grant_nxt;
`ifdef BIST_ACCESS_CNT_EN
  logic [15:0]           acc_cnt_nxt;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NORMAL;
      settle_cnt <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      func_stall <= 1'b0;
      bist_grant <= 1'b0;
`ifdef BIST_ACCESS_CNT_EN
      bist_access_cnt <= 16'h0000;
`endif
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      mem_cs     <= mem_cs_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      func_stall <= func_stall_nxt;
      bist_grant <= bist_grant_nxt;
`ifdef BIST_ACCESS_CNT_EN
      bist_access_cnt <= acc_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    mem_cs_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    func_stall_nxt = func_stall;
    bist_grant_nxt = bist_grant;
`ifdef BIST_ACCESS_CNT_EN
    acc_cnt_nxt    = bist_access_cnt;
`endif

    case (state)
      ST_NORMAL: begin
        // The access presented alongside the request is still forwarded.
        mem_cs_nxt   = func_cs;
        mem_we_nxt   = func_we;
        mem_addr_nxt = func_addr;
        mem_din_nxt  = func_din;
        if (NbarT) begin
          state_nxt      = ST_ENTER;
          settle_cnt_nxt = SETTLE_LOAD;
          func_stall_nxt = 1'b1;
`ifdef BIST_ACCESS_CNT_EN
          acc_cnt_nxt    = 16'h0000;
`endif
        end
      end

      ST_ENTER: begin
        if (!NbarT) begin
          state_nxt      = ST_EXIT;
          settle_cnt_nxt = SETTLE_LOAD;
        end else if (settle_cnt == '0) begin
          state_nxt      = ST_TEST;
          bist_grant_nxt = 1'b1;
        end else begin
          settle_cnt_nxt = settle_cnt - CNT_W'(1);
        end
      end

      ST_TEST: begin
        mem_addr_nxt = bist_addr;
        mem_din_nxt  = bist_din;
        if (!NbarT) begin
          // BIST access presented on the exit request is dropped.
          state_nxt      = ST_EXIT;
          settle_cnt_nxt = SETTLE_LOAD;
          bist_grant_nxt = 1'b0;
        end else begin
          mem_cs_nxt = bist_cs;
          mem_we_nxt = bist_we;
`ifdef BIST_ACCESS_CNT_EN
          if (bist_cs && (bist_access_cnt != 16'hFFFF))
            acc_cnt_nxt = bist_access_cnt + 16'd1;
`endif
        end
      end

      default: begin // ST_EXIT: NbarT ignored until back in NORMAL
        if (settle_cnt == '0) begin
          state_nxt      = ST_NORMAL;
          func_stall_nxt = 1'b0;
        end else begin
          settle_cnt_nxt = settle_cnt - CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bist_access_arbiter.sv
// Directed, table-driven bench for bist_access_arbiter (default parameters,
// SETTLE_CYCLES = 2) plus hand sequences for reset mid-TEST and the optional
// BIST access counter.
module tb_bist_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       NbarT;
  logic       func_cs, func_we;
  logic [5:0] func_addr;
  logic [7:0] func_din;
  logic       bist_cs, bist_we;
  logic [5:0] bist_addr;
  logic [7:0] bist_din;
  logic       mem_cs, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic       func_stall, bist_grant;
`ifdef BIST_ACCESS_CNT_EN
  logic [15:0] bist_access_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bist_access_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .NbarT      (NbarT),
    .func_cs    (func_cs),
    .func_we    (func_we),
    .func_addr  (func_addr),
    .func_din   (func_din),
    .bist_cs    (bist_cs),
    .bist_we    (bist_we),
    .bist_addr  (bist_addr),
    .bist_din   (bist_din),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .func_stall (func_stall),
`ifdef BIST_ACCESS_CNT_EN
    .bist_access_cnt (bist_access_cnt),
`endif
    .bist_grant (bist_grant)
  );

  typedef struct {
    logic       nbart;
    logic       fcs, fwe;
    logic [5:0] faddr;
    logic [7:0] fdin;
    logic       bcs, bwe;
    logic [5:0] baddr;
    logic [7:0] bdin;
    logic       e_cs, e_we;
    logic [5:0] e_addr;
    logic [7:0] e_din;
    logic       e_stall, e_grant;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input logic cs, input logic we,
                           input logic [5:0] addr, input logic [7:0] din,
                           input logic stall, input logic grant);
    check("mem_cs", step, 32'(mem_cs), 32'(cs));
    check("mem_we", step, 32'(mem_we), 32'(we));
    check("mem_addr", step, 32'(mem_addr), 32'(addr));
    check("mem_din", step, 32'(mem_din), 32'(din));
    check("func_stall", step, 32'(func_stall), 32'(stall));
    check("bist_grant", step, 32'(bist_grant), 32'(grant));
  endtask

  task automatic drive(input logic n, input logic fcs, input logic fwe,
                       input logic [5:0] fa, input logic [7:0] fd,
                       input logic bcs, input logic bwe,
                       input logic [5:0] ba, input logic [7:0] bd);
    NbarT = n; func_cs = fcs; func_we = fwe; func_addr = fa; func_din = fd;
    bist_cs = bcs; bist_we = bwe; bist_addr = ba; bist_din = bd;
  endtask

  // One vector: functional side f (15/A5 write), BIST side b (2A/3C read)
  function automatic vec_t mk(input logic n, input logic e_cs, input logic e_we,
                              input logic [5:0] e_a, input logic [7:0] e_d,
                              input logic e_s, input logic e_g);
    vec_t v;
    v.nbart = n;
    v.fcs = 1'b1; v.fwe = 1'b1; v.faddr = 6'h15; v.fdin = 8'hA5;
    v.bcs = 1'b1; v.bwe = 1'b0; v.baddr = 6'h2A; v.bdin = 8'h3C;
    v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_a; v.e_din = e_d;
    v.e_stall = e_s; v.e_grant = e_g;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00);

    // Normal forwarding
    vecs[0]  = mk(1'b0, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 6'h0A, 8'h5A, 1'b0, 1'b0);
    vecs[1].fwe = 1'b0; vecs[1].faddr = 6'h0A; vecs[1].fdin = 8'h5A;
    // Entry: E0 forwards, E1/E2 quiet, grant after E2, BIST after E3
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 6'h15, 8'hA5, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 6'h15, 8'hA5, 1'b1, 1'b1);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 6'h2A, 8'h3C, 1'b1, 1'b1);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 6'h3F, 8'hFF, 1'b1, 1'b1);
    vecs[6].bwe = 1'b1; vecs[6].baddr = 6'h3F; vecs[6].bdin = 8'hFF;
    // Exit: X0 drops grant and strobe, stall clears after X2, NbarT ignored
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 6'h2A, 8'h3C, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 6'h2A, 8'h3C, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 6'h2A, 8'h3C, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b0, 1'b0);
    // One-cycle NbarT pulse: ENTER -> EXIT -> NORMAL, three quiet cycles
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 6'h15, 8'hA5, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 6'h15, 8'hA5, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 6'h15, 8'hA5, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b0, 1'b0);

    #12;
    check_all(-1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
`ifdef BIST_ACCESS_CNT_EN
    check("cnt_reset", -1, 32'(bist_access_cnt), 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].nbart, vecs[i].fcs, vecs[i].fwe, vecs[i].faddr, vecs[i].fdin,
            vecs[i].bcs, vecs[i].bwe, vecs[i].baddr, vecs[i].bdin);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_cs, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din,
                vecs[i].e_stall, vecs[i].e_grant);
      @(negedge clk);
    end

    // Reset asserted mid-TEST with a BIST write in flight
    drive(1'b1, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b1, 1'b1, 6'h2A, 8'h3C);
    repeat (4) @(posedge clk);
    #1;
    check_all(100, 1'b1, 1'b1, 6'h2A, 8'h3C, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(101, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b1, 1'b1, 6'h2A, 8'h3C);
    @(posedge clk);
    #1;
    check_all(102, 1'b1, 1'b1, 6'h15, 8'hA5, 1'b0, 1'b0);

`ifdef BIST_ACCESS_CNT_EN
    // Five forwarded BIST accesses, one idle cycle, and a dropped exit access
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h01, 8'h11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bist_cs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bist_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bist_cs = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    NbarT = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_after_5", 200, 32'(bist_access_cnt), 32'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cnt_hold_exit", 201, 32'(bist_access_cnt), 32'd5);
    NbarT = 1'b1;
    @(posedge clk);
    #1;
    check("cnt_clear", 202, 32'(bist_access_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
